truth_table_sweep: RTL and testbench



---
 rtl/truth_table_sweep.sv | 119 +++++++++++
 tb/tb_truth_table_sweep.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweep.sv
// Sweeps the three inputs of a combinational block through all eight codes,
// captures its output into a truth table and grades it against a golden pattern.
module truth_table_sweep #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [7:0]  EXPECTED = 8'h8A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_s,
    output logic       o_x,
    output logic       o_y,
    output logic       o_z,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_table,
    output logic       o_pass,
    output logic [3:0] o_err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

    state_t     r_state, w_state_next;
    logic [2:0] r_idx, w_idx_next;
    logic [3:0] r_cnt, w_cnt_next;
    logic [7:0] r_table, w_table_next;
    logic       r_pass, w_pass_next;
    logic [3:0] r_err_count, w_err_count_next;
    logic [7:0] w_table_captured;
    logic [7:0] w_diff;

    // Table as it will look after this edge's capture, so the verdict on the
    // final vector already includes the bit being written.
    always_comb begin
        w_table_captured        = r_table;
        w_table_captured[r_idx] = i_s;
        w_diff                  = w_table_captured ^ EXPECTED;
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_cnt_next       = r_cnt;
        w_table_next     = r_table;
        w_pass_next      = r_pass;
        w_err_count_next = r_err_count;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next     = ST_RUN;
                    w_idx_next       = 3'd0;
                    w_cnt_next       = CNT_RELOAD;
                    w_table_next     = 8'h00;
                    w_pass_next      = 1'b0;
                    w_err_count_next = 4'd0;
                end
            end
            ST_RUN: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_table_next = w_table_captured;
                    if (r_idx == 3'd7) begin
                        w_state_next     = ST_DONE;
                        w_pass_next      = (w_diff == 8'h00);
                        w_err_count_next = 4'($countones(w_diff));
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                        w_cnt_next = CNT_RELOAD;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_cnt       <= 4'd0;
            r_table     <= 8'h00;
            r_pass      <= 1'b0;
            r_err_count <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_cnt       <= w_cnt_next;
            r_table     <= w_table_next;
            r_pass      <= w_pass_next;
            r_err_count <= w_err_count_next;
        end
    end

    // Stimulus comes straight from the registered index, gated to zero outside RUN.
    assign o_busy            = (r_state == ST_RUN);
    assign o_done            = (r_state == ST_DONE);
    assign {o_x, o_y, o_z}   = o_busy ? r_idx : 3'b000;
    assign o_table           = r_table;
    assign o_pass            = r_pass;
    assign o_err_count       = r_err_count;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep: one instance at SETTLE=1, one at SETTLE=3,
// each wired to a model of fxyz with optional stuck-at overrides on s.
module tb_truth_table_sweep;

    logic clk;
    logic rst_n;
    logic start_drv;
    logic sel_b;
    int   a_mode;
    int   checks;
    int   errors;

    logic       a_start, a_s, a_x, a_y, a_z, a_busy, a_done, a_pass;
    logic [7:0] a_table;
    logic [3:0] a_err;
    logic       b_start, b_s, b_x, b_y, b_z, b_busy, b_done, b_pass;
    logic [7:0] b_table;
    logic [3:0] b_err;

    logic       m_x, m_y, m_z, m_busy, m_done, m_pass;
    logic [7:0] m_table;
    logic [3:0] m_err;

    function automatic logic fxyz(input logic x, input logic y, input logic z);
        return ~(x & ~y) & z;
    endfunction

    assign a_start = start_drv & ~sel_b;
    assign b_start = start_drv & sel_b;
    assign a_s = (a_mode == 1) ? 1'b0 : (a_mode == 2) ? 1'b1 : fxyz(a_x, a_y, a_z);
    assign b_s = fxyz(b_x, b_y, b_z);

    assign {m_x, m_y, m_z, m_busy, m_done, m_table, m_pass, m_err} = sel_b ?
        {b_x, b_y, b_z, b_busy, b_done, b_table, b_pass, b_err} :
        {a_x, a_y, a_z, a_busy, a_done, a_table, a_pass, a_err};

    truth_table_sweep #(.SETTLE(1), .EXPECTED(8'h8A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_s(a_s),
        .o_x(a_x), .o_y(a_y), .o_z(a_z), .o_busy(a_busy), .o_done(a_done),
        .o_table(a_table), .o_pass(a_pass), .o_err_count(a_err)
    );

    truth_table_sweep #(.SETTLE(3), .EXPECTED(8'h8A)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_s(b_s),
        .o_x(b_x), .o_y(b_y), .o_z(b_z), .o_busy(b_busy), .o_done(b_done),
        .o_table(b_table), .o_pass(b_pass), .o_err_count(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, {15'd0, a_x, a_y, a_z, a_busy, a_done, a_table, a_pass, a_err}, 32'd0);
        chk({tag, "_b"}, {15'd0, b_x, b_y, b_z, b_busy, b_done, b_table, b_pass, b_err}, 32'd0);
    endtask

    // Launch one sweep on the selected instance and grade it end to end.
    task automatic sweep(input int settle, input logic [7:0] exp_table, input logic exp_pass,
                         input logic [3:0] exp_err, input bit pulse_ignored);
        int busy_n;
        int n;
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        chk("busy_after_start", m_busy, 1'b1);
        busy_n = 0;
        n = 0;
        while (!m_done && n < 200) begin
            if (m_busy) begin
                chk("xyz_vector", {29'd0, m_x, m_y, m_z}, busy_n / settle);
                busy_n++;
            end
            if (pulse_ignored)
                start_drv = m_busy && ({m_x, m_y, m_z} == 3'd2 || {m_x, m_y, m_z} == 3'd5);
            @(negedge clk);
            n++;
        end
        start_drv = 1'b0;
        chk("done_seen", m_done, 1'b1);
        chk("busy_cycles", busy_n, 8 * settle);
        chk("done_busy_low", m_busy, 1'b0);
        chk("done_xyz_zero", {m_x, m_y, m_z}, 3'd0);
        chk("table", m_table, exp_table);
        chk("pass", m_pass, exp_pass);
        chk("err_count", m_err, exp_err);
        if (pulse_ignored) begin
            start_drv = 1'b1;
            @(negedge clk);
            start_drv = 1'b0;
            repeat (10) begin
                chk("ignored_busy", m_busy, 1'b0);
                chk("ignored_done", m_done, 1'b0);
                @(negedge clk);
            end
        end else begin
            @(negedge clk);
            chk("done_single", m_done, 1'b0);
            chk("table_held", m_table, exp_table);
        end
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        start_drv = 1'b0;
        sel_b     = 1'b0;
        a_mode    = 0;

        // Asynchronous reset asserted between edges.
        #23 rst_n = 1'b0;
        #1 chk_all_zero("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy_a", a_busy, 1'b0);
            chk("idle_busy_b", b_busy, 1'b0);
        end

        // SETTLE=1: golden and stuck-at patterns.
        sweep(1, 8'h8A, 1'b1, 4'd0, 1'b0);
        a_mode = 1;
        sweep(1, 8'h00, 1'b0, 4'd3, 1'b0);
        a_mode = 2;
        sweep(1, 8'hFF, 1'b0, 4'd5, 1'b0);
        a_mode = 0;

        // Stray starts in RUN and DONE must not spawn another sweep.
        sweep(1, 8'h8A, 1'b1, 4'd0, 1'b1);

        // SETTLE=3 instance.
        sel_b = 1'b1;
        sweep(3, 8'h8A, 1'b1, 4'd0, 1'b0);
        sel_b = 1'b0;

        // Abort with s stuck high at vector 4, then a clean sweep.
        a_mode = 2;
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        n = 0;
        while (!(a_busy && {a_x, a_y, a_z} == 3'd4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_idx4", {a_busy, a_x, a_y, a_z}, 4'b1100);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset_mid_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        a_mode = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_idle", a_busy, 1'b0);
        end
        sweep(1, 8'h8A, 1'b1, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
